alu_req_arbiter: RTL

- Shares one alu16 instance between NUM_REQ independent requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin grant; one operation in flight at a time.
- Drives the ALU operand/opcode/carry_in inputs, waits the ALU latency, captures result/carry_out, returns it to the granted requester.
- Sits between the requester blocks and alu16 in the datapath top level.

---
 rtl/alu_ctrl_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/alu_req_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/state types and helpers for the ALU request arbiter.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  localparam logic [15:0] ALU_ERR_RESULT = 16'hBAD1;

  function automatic logic op_supported(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot pick over req, lowest index at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt_idx    = idx;
        gnt[idx]   = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner on each accepted grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters, one operation in flight.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned DATA_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*4-1:0]       req_opcode,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0]         req_carry_in,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]          rsp_result,
  output logic                       rsp_carry_out,
  output logic                       rsp_error,
  output logic [DATA_W-1:0]          alu_operand_a,
  output logic [DATA_W-1:0]          alu_operand_b,
  output logic [3:0]                 alu_opcode,
  output logic                       alu_carry_in,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic                       alu_carry_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 2);

  ctrl_state_e       state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [3:0]        sel_opcode;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              sel_cin, sel_ok;
  logic              accept, capture, rsp_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_opcode = req_opcode[int'(gnt_idx)*4 +: 4];
  assign sel_a      = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_b      = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_cin    = req_carry_in[gnt_idx];
  assign sel_ok     = op_supported(sel_opcode);

  // Next state and control strobes; req_ready is the live arbitration result in IDLE
  always_comb begin
    state_n   = state;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        accept    = |(req_valid & gnt);
        if (accept) state_n = sel_ok ? EXEC : RESP;
      end
      EXEC: begin
        if (cnt == CNT_W'(ALU_LATENCY)) begin
          capture = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grant_id]) begin
          rsp_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      grant_id      <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_opcode    <= '0;
      alu_carry_in  <= 1'b0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_carry_out <= 1'b0;
      rsp_error     <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      if (state == EXEC) cnt <= cnt + CNT_W'(1);
      if (accept) begin
        grant_id <= gnt_idx;
        cnt      <= '0;
        if (sel_ok) begin
          alu_operand_a <= sel_a;
          alu_operand_b <= sel_b;
          alu_opcode    <= sel_opcode;
          alu_carry_in  <= sel_cin;
        end else begin
          // Unsupported opcode bypasses the ALU and answers next cycle
          rsp_result    <= DATA_W'(ALU_ERR_RESULT);
          rsp_carry_out <= 1'b0;
          rsp_error     <= 1'b1;
          rsp_valid     <= gnt;
        end
      end
      if (capture) begin
        rsp_result    <= alu_result;
        rsp_carry_out <= alu_carry_out;
        rsp_error     <= 1'b0;
        rsp_valid     <= NUM_REQ'(1) << grant_id;
      end
      if (rsp_done) rsp_valid <= '0;
    end
  end

endmodule
